// File: rtl/sc_tx_port_pkg.sv
// Shared definitions for the SIE transmit port: command codes, SIE byte types,
// FSM states and the reflected USB CRC16 polynomial.
package sc_tx_port_pkg;

  localparam logic [7:0] CMD_DIRECT = 8'h00;
  localparam logic [7:0] CMD_DATA   = 8'h01;
  localparam logic [7:0] CMD_START  = 8'h02;
  localparam logic [7:0] CMD_STOP   = 8'h03;

  localparam logic [1:0] CTL_DATA   = 2'd0;
  localparam logic [1:0] CTL_START  = 2'd1;
  localparam logic [1:0] CTL_STOP   = 2'd2;
  localparam logic [1:0] CTL_DIRECT = 2'd3;

  localparam logic [15:0] CRC16_POLY = 16'hA001;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    CRC_LO,
    CRC_HI,
    STOP
  } txState_t;

endpackage

// File: rtl/usb_crc16_byte.sv
// One-byte USB CRC16 update (reflected form, LSB first), purely combinational.
module usb_crc16_byte
  import sc_tx_port_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  dataByte,
  output logic [15:0] crc_out
);

  logic [15:0] crcWork;

  always_comb begin
    crcWork = crc_in ^ {8'h00, dataByte};
    for (int i = 0; i < 8; i++) begin
      crcWork = crcWork[0] ? ((crcWork >> 1) ^ CRC16_POLY) : (crcWork >> 1);
    end
    crc_out = crcWork;
  end

endmodule

// File: rtl/sc_tx_port.sv
// Transmit port between the arbiter and the SIE: turns command writes into SIE bytes.
// Define SC_TX_CRC16_EN to append the USB CRC16 to data packets on PACKET_STOP.
module sc_tx_port
  import sc_tx_port_pkg::*;
#(
  parameter logic [15:0] CRC16_INIT = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCTxPortWEn,
  input  logic [7:0] SCTxPortData,
  input  logic [7:0] SCTxPortCntl,
  output logic       SCTxPortRdy,
  output logic [7:0] sieTxByte,
  output logic [1:0] sieTxCtl,
  output logic       sieTxWEn,
  input  logic       sieTxRdy
);

  txState_t    state, stateNxt;
  logic        rdyNxt;
  logic [7:0]  byteNxt;
  logic [1:0]  ctlNxt;
  logic        inPacket, inPacketNxt;
  logic        crcActive, crcActiveNxt;
  logic [15:0] crc, crcNxt, crcUpd;
  logic        accept;

  usb_crc16_byte uCrc (
    .crc_in  (crc),
    .dataByte(SCTxPortData),
    .crc_out (crcUpd)
  );

  assign accept   = SCTxPortWEn && SCTxPortRdy;
  // A byte is pending in every non-IDLE state; it goes out when the SIE is ready.
  assign sieTxWEn = (state != IDLE) && sieTxRdy;

  always_comb begin
    stateNxt     = state;
    byteNxt      = sieTxByte;
    ctlNxt       = sieTxCtl;
    inPacketNxt  = inPacket;
    crcActiveNxt = crcActive;
    crcNxt       = crc;
    unique case (state)
      IDLE: begin
        if (accept) begin
          case (SCTxPortCntl)
            CMD_DIRECT: begin
              byteNxt  = SCTxPortData;
              ctlNxt   = CTL_DIRECT;
              stateNxt = SEND;
            end
            CMD_DATA: begin
              byteNxt  = SCTxPortData;
              ctlNxt   = CTL_DATA;
              stateNxt = SEND;
              if (inPacket && crcActive) crcNxt = crcUpd;
            end
            CMD_START: begin
              byteNxt     = SCTxPortData;
              ctlNxt      = CTL_START;
              stateNxt    = SEND;
              crcNxt      = CRC16_INIT;
              inPacketNxt = 1'b1;
`ifdef SC_TX_CRC16_EN
              crcActiveNxt = (SCTxPortData[1:0] == 2'b11);
`else
              crcActiveNxt = 1'b0;
`endif
            end
            CMD_STOP: begin
              inPacketNxt  = 1'b0;
              crcActiveNxt = 1'b0;
              if (inPacket && crcActive) begin
                byteNxt  = ~crc[7:0];
                ctlNxt   = CTL_DATA;
                stateNxt = CRC_LO;
              end else begin
                byteNxt  = 8'h00;
                ctlNxt   = CTL_STOP;
                stateNxt = STOP;
              end
            end
            default: ;
          endcase
        end
      end
      SEND: if (sieTxWEn) stateNxt = IDLE;
      CRC_LO: begin
        if (sieTxWEn) begin
          byteNxt  = ~crc[15:8];
          ctlNxt   = CTL_DATA;
          stateNxt = CRC_HI;
        end
      end
      CRC_HI: begin
        if (sieTxWEn) begin
          byteNxt  = 8'h00;
          ctlNxt   = CTL_STOP;
          stateNxt = STOP;
        end
      end
      STOP: if (sieTxWEn) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
    // Ready is only offered while idle and not in the cycle right after an acceptance.
    rdyNxt = (stateNxt == IDLE) && !accept;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      SCTxPortRdy <= 1'b0;
      sieTxByte   <= 8'h00;
      sieTxCtl    <= 2'd0;
      inPacket    <= 1'b0;
      crcActive   <= 1'b0;
      crc         <= CRC16_INIT;
    end else begin
      state       <= stateNxt;
      SCTxPortRdy <= rdyNxt;
      sieTxByte   <= byteNxt;
      sieTxCtl    <= ctlNxt;
      inPacket    <= inPacketNxt;
      crcActive   <= crcActiveNxt;
      crc         <= crcNxt;
    end
  end

endmodule
